planar_neighbor_writer: RTL
===========================

# planar_neighbor_writer

Write-back side of the planar reference-sample RAM. After a 4x4 planar block is reconstructed, this block takes its four rows. It writes the bottom row into the top-neighbour RAM at addresses X..X+3 and the right column into the left-neighbour RAM at addresses Y..Y+3. It uses the same 8-bit ADDRESS_RAM bus that the planar address generator uses for reads, and sits between the reconstruction adder and the neighbour RAMs.

## Interface
Parameters:
- SAMPLE_W, 8, bit width of one reconstructed sample
- ADDR_W, 8, neighbour-RAM address width

Ports:
- CLK, input, 1, single clock, rising edge
- RST, input, 1, reset: synchronous, active-high
- START, input, 1, one-cycle pulse that latches X and Y and begins a block
- X, input, 6, horizontal position of the block in the top RAM
- Y, input, 6, vertical position of the block in the left RAM
- REC_VALID, input, 1, a reconstructed row is present on REC_ROW
- REC_ROW, input, 4*SAMPLE_W, one row; sample 0 is in the LSBs
- REC_READY, output, 1, the block accepts a row this cycle
- ADDRESS_RAM, output, ADDR_W, write address
- DATA_RAM, output, SAMPLE_W, write data
- WE_TOP, output, 1, write strobe for the top RAM
- WE_LEFT, output, 1, write strobe for the left RAM
- BUSY, output, 1, high in every state except IDLE
- DONE, output, 1, one-cycle pulse after the last write

## Operation
- States and transitions:
  - IDLE: START goes to COLLECT.
  - COLLECT: accepts 4 rows, then goes to WR_TOP.
  - WR_TOP: 4 writes, then goes to WR_LEFT.
  - WR_LEFT: 4 writes, then goes to FIN (or to WR_CORNER, see Configuration).
  - FIN: goes to IDLE.
- START: latch X and Y into registers, zero-extended to ADDR_W. START in any state other than IDLE is ignored.
- COLLECT:
  - REC_READY = 1.
  - On each REC_VALID & REC_READY, a 2-bit row counter increments.
  - Every accepted row stores its sample 3 into rcol[row].
  - Row 3 is stored whole into brow[0..3].
  - REC_READY drops in the cycle after the 4th row is accepted.
- WR_TOP, cycle k = 0..3:
  - ADDRESS_RAM = X+k, DATA_RAM = brow[k].
  - WE_TOP = 1, WE_LEFT = 0.
- WR_LEFT, cycle k = 0..3:
  - ADDRESS_RAM = Y+k, DATA_RAM = rcol[k].
  - WE_LEFT = 1, WE_TOP = 0.
- FIN: DONE = 1 for one cycle, then IDLE.
- Address arithmetic:
  - 8-bit unsigned. The largest address is 63+3 = 66, so there is no wrap-around.
  - Addresses come from an offset counter added to the latched base. Do not increment ADDRESS_RAM itself.
- WE_TOP and WE_LEFT are never high in the same cycle, except in WR_CORNER.

## Timing
- All outputs are registered.
- Reset values: ADDRESS_RAM=0, DATA_RAM=0, WE_TOP=0, WE_LEFT=0, REC_READY=0, BUSY=0, DONE=0. State = IDLE, counters = 0.
- Cycle-level sequence:
  - START sampled at edge n: BUSY=1 and REC_READY=1 from cycle n+1.
  - 4th row accepted at edge m: the first WE_TOP is in cycle m+1.
  - The last WE_LEFT is in cycle m+8.
  - DONE is in cycle m+9, and BUSY=0 from m+10.
- Minimum latency from START to DONE is 13 cycles with back-to-back rows.
- REC_VALID low in COLLECT: hold the state and counter. No timeout.
- REC_VALID while REC_READY=0: the row is ignored and not captured.
- RST asserted in any state: next edge returns all outputs and state to reset values. Partial writes are abandoned; the neighbour RAM content is the caller's concern.
- START in the same cycle as DONE is ignored. START is accepted from IDLE only.

## Configuration
- PLANAR_CORNER_WR_EN defined:
  - An extra WR_CORNER state follows WR_LEFT.
  - It writes brow[3] (sample 3,3) to ADDRESS_RAM = 8'hFF with WE_TOP = WE_LEFT = 1. This is the top-left corner seed for the next block.
  - DONE moves one cycle later (m+10).
- Not defined: no WR_CORNER state, and both strobes never assert together.

## Structure
- Shared package planar_pkg holds:
  - the state encoding (IDLE, COLLECT, WR_TOP, WR_LEFT, WR_CORNER, FIN)
  - ADDR_W and SAMPLE_W defaults
  - the CORNER_ADDR = 8'hFF constant
- One sub-module, planar_row_capture: the row counter plus the brow/rcol register file, with accept and clear inputs.
- The FSM and address/data mux stay in the top level.

## Test plan
- Nominal block:
  - Stimulus: X=4, Y=8; rows 0x03020100, 0x13121110, 0x23222120, 0x33323130 on consecutive cycles.
  - Required: WE_TOP writes 0x30, 0x31, 0x32, 0x33 to addresses 4..7.
  - Required: WE_LEFT writes 0x03, 0x13, 0x23, 0x33 to addresses 8..11.
  - Required: DONE at START+13.
- Gapped input: REC_VALID low for 3 cycles between rows 1 and 2 -> identical write sequence, DONE delayed by 3 cycles.
- Boundary: X=63, Y=63 -> addresses 63..66 on both RAMs, with no wrap.
- START while BUSY: a second START during WR_TOP is ignored; the first block completes unchanged.
- Reset mid-operation: RST during WR_LEFT k=1 -> next cycle all outputs are 0 and the state is IDLE. A subsequent START runs a clean block.
- PLANAR_CORNER_WR_EN build: nominal stimulus -> an extra write of 0x33 to 0xFF with both strobes high, DONE at START+14.

Source files
------------

// File: rtl/planar_pkg.sv
// Shared definitions for the planar neighbour write-back path: FSM state
// encoding, default widths and the corner-seed address.
package planar_pkg;

    localparam int SAMPLE_W_DEF = 8;
    localparam int ADDR_W_DEF   = 8;

    // Top-left corner seed location, written only in corner-enabled builds
    localparam logic [7:0] CORNER_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COLLECT   = 3'd1,
        WR_TOP    = 3'd2,
        WR_LEFT   = 3'd3,
        WR_CORNER = 3'd4,
        FIN       = 3'd5
    } state_t;

endpackage

// File: rtl/planar_row_capture.sv
// Row capture for one 4x4 planar block: a 2-bit row counter plus the
// bottom-row (brow) and right-column (rcol) sample registers.
// i_clear restarts the counter for a new block; i_accept stores one row.
module planar_row_capture
    import planar_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_accept,
    input  logic                  i_clear,
    input  logic [4*SAMPLE_W-1:0] i_row,
    output logic [1:0]            o_row_cnt,
    output logic [SAMPLE_W-1:0]   o_brow [4],
    output logic [SAMPLE_W-1:0]   o_rcol [4]
);

    logic [1:0]          r_row_cnt;
    logic [SAMPLE_W-1:0] r_brow [4];
    logic [SAMPLE_W-1:0] r_rcol [4];

    // Row counter: cleared on a new block, advanced on each accepted row
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt <= 2'd0;
        end else if (i_clear) begin
            r_row_cnt <= 2'd0;
        end else if (i_accept) begin
            r_row_cnt <= r_row_cnt + 2'd1;
        end
    end

    // Sample storage: every row contributes its sample 3, row 3 is kept whole
    always_ff @(posedge clk) begin
        if (i_accept) begin
            r_rcol[r_row_cnt] <= i_row[3*SAMPLE_W +: SAMPLE_W];
            if (r_row_cnt == 2'd3) begin
                for (int i = 0; i < 4; i++) begin
                    r_brow[i] <= i_row[i*SAMPLE_W +: SAMPLE_W];
                end
            end
        end
    end

    assign o_row_cnt = r_row_cnt;
    assign o_brow    = r_brow;
    assign o_rcol    = r_rcol;

endmodule

// File: rtl/planar_neighbor_writer.sv
// Planar neighbour write-back: collects the four reconstructed rows of a
// 4x4 block, then writes the bottom row to the top-neighbour RAM at X..X+3
// and the right column to the left-neighbour RAM at Y..Y+3 over the shared
// ADDRESS_RAM bus. All outputs are registered from next-state decode.
// Optional feature macro: PLANAR_CORNER_WR_EN adds a WR_CORNER state that
// writes sample (3,3) to CORNER_ADDR with both strobes high.
module planar_neighbor_writer
    import planar_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [5:0]            X,
    input  logic [5:0]            Y,
    input  logic                  REC_VALID,
    input  logic [4*SAMPLE_W-1:0] REC_ROW,
    output logic                  REC_READY,
    output logic [ADDR_W-1:0]     ADDRESS_RAM,
    output logic [SAMPLE_W-1:0]   DATA_RAM,
    output logic                  WE_TOP,
    output logic                  WE_LEFT,
    output logic                  BUSY,
    output logic                  DONE
);

    state_t              r_state;
    state_t              w_state_d;
    logic [1:0]          r_off;
    logic [1:0]          w_off_d;

    logic [ADDR_W-1:0]   r_x_base;
    logic [ADDR_W-1:0]   r_y_base;

    logic                r_rec_ready;
    logic [ADDR_W-1:0]   r_addr;
    logic [SAMPLE_W-1:0] r_data;
    logic                r_we_top;
    logic                r_we_left;
    logic                r_busy;
    logic                r_done;

    logic [ADDR_W-1:0]   w_addr_d;
    logic [SAMPLE_W-1:0] w_data_d;
    logic                w_we_top_d;
    logic                w_we_left_d;
    logic [ADDR_W-1:0]   w_off_ext;

    logic                w_accept;
    logic                w_start_ok;
    logic                w_last_row;
    logic [1:0]          w_row_cnt;
    logic [SAMPLE_W-1:0] w_brow [4];
    logic [SAMPLE_W-1:0] w_rcol [4];

    // A row is taken only while the registered ready is high; START only from IDLE
    assign w_accept   = r_rec_ready & REC_VALID;
    assign w_start_ok = (r_state == IDLE) & START;
    assign w_last_row = w_accept & (w_row_cnt == 2'd3);
    assign w_off_ext  = {{(ADDR_W-2){1'b0}}, w_off_d};

    planar_row_capture #(
        .SAMPLE_W (SAMPLE_W)
    ) u_capture (
        .clk       (CLK),
        .rst       (RST),
        .i_accept  (w_accept),
        .i_clear   (w_start_ok),
        .i_row     (REC_ROW),
        .o_row_cnt (w_row_cnt),
        .o_brow    (w_brow),
        .o_rcol    (w_rcol)
    );

    // State and write-offset registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_off   <= 2'd0;
        end else begin
            r_state <= w_state_d;
            r_off   <= w_off_d;
        end
    end

    // Block base addresses, zero-extended and latched when a block starts
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_x_base <= '0;
            r_y_base <= '0;
        end else if (w_start_ok) begin
            r_x_base <= {{(ADDR_W-6){1'b0}}, X};
            r_y_base <= {{(ADDR_W-6){1'b0}}, Y};
        end
    end

    // Next-state logic and next-cycle write-port values
    always_comb begin
        w_state_d   = r_state;
        w_off_d     = r_off;
        w_addr_d    = '0;
        w_data_d    = '0;
        w_we_top_d  = 1'b0;
        w_we_left_d = 1'b0;

        case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_d = COLLECT;
                    w_off_d   = 2'd0;
                end
            end
            COLLECT: begin
                if (w_last_row) begin
                    w_state_d = WR_TOP;
                    w_off_d   = 2'd0;
                end
            end
            WR_TOP: begin
                if (r_off == 2'd3) begin
                    w_state_d = WR_LEFT;
                    w_off_d   = 2'd0;
                end else begin
                    w_off_d = r_off + 2'd1;
                end
            end
            WR_LEFT: begin
                if (r_off == 2'd3) begin
`ifdef PLANAR_CORNER_WR_EN
                    w_state_d = WR_CORNER;
`else
                    w_state_d = FIN;
`endif
                    w_off_d = 2'd0;
                end else begin
                    w_off_d = r_off + 2'd1;
                end
            end
`ifdef PLANAR_CORNER_WR_EN
            WR_CORNER: begin
                w_state_d = FIN;
            end
`endif
            FIN: begin
                w_state_d = IDLE;
            end
            default: begin
                w_state_d = IDLE;
                w_off_d   = 2'd0;
            end
        endcase

        case (w_state_d)
            WR_TOP: begin
                w_addr_d   = r_x_base + w_off_ext;
                // On entry the bottom row is still being captured this edge,
                // so its sample 0 is taken straight from the input row.
                w_data_d   = (r_state == COLLECT) ? REC_ROW[SAMPLE_W-1:0]
                                                  : w_brow[w_off_d];
                w_we_top_d = 1'b1;
            end
            WR_LEFT: begin
                w_addr_d    = r_y_base + w_off_ext;
                w_data_d    = w_rcol[w_off_d];
                w_we_left_d = 1'b1;
            end
`ifdef PLANAR_CORNER_WR_EN
            WR_CORNER: begin
                w_addr_d    = ADDR_W'(CORNER_ADDR);
                w_data_d    = w_brow[3];
                w_we_top_d  = 1'b1;
                w_we_left_d = 1'b1;
            end
`endif
            default: begin
                w_addr_d = '0;
            end
        endcase
    end

    // Registered outputs, all decoded from the state being entered
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rec_ready <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_we_top    <= 1'b0;
            r_we_left   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rec_ready <= (w_state_d == COLLECT);
            r_addr      <= w_addr_d;
            r_data      <= w_data_d;
            r_we_top    <= w_we_top_d;
            r_we_left   <= w_we_left_d;
            r_busy      <= (w_state_d != IDLE);
            r_done      <= (w_state_d == FIN);
        end
    end

    assign REC_READY   = r_rec_ready;
    assign ADDRESS_RAM = r_addr;
    assign DATA_RAM    = r_data;
    assign WE_TOP      = r_we_top;
    assign WE_LEFT     = r_we_left;
    assign BUSY        = r_busy;
    assign DONE        = r_done;

endmodule
